// File: rtl/fwd_scoreboard_if.sv
// Decode-side bundle of the forwarding scoreboard: operand requests, destination
// info, in-flight results and resolved operands.
interface fwd_scoreboard_if #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned NREG   = 32,
  parameter int unsigned STAGES = 3
);
  localparam int unsigned AW = $clog2(NREG);
  localparam int unsigned LW = $clog2(STAGES + 1);

  logic                   id_valid_i;
  logic                   id_ready_o;
  logic                   flush_i;
  logic [AW-1:0]          rs1_addr_i;
  logic [AW-1:0]          rs2_addr_i;
  logic                   rs1_re_i;
  logic                   rs2_re_i;
  logic [AW-1:0]          rd_addr_i;
  logic                   rd_we_i;
  logic [LW-1:0]          rd_lat_i;
  logic [XLEN-1:0]        rs1_rf_data_i;
  logic [XLEN-1:0]        rs2_rf_data_i;
  logic [STAGES*XLEN-1:0] stage_data_i;
  logic [XLEN-1:0]        rs1_data_o;
  logic [XLEN-1:0]        rs2_data_o;
  logic [STAGES-1:0]      rs1_fwd_o;
  logic [STAGES-1:0]      rs2_fwd_o;
  logic                   stall_o;
  logic [15:0]            stall_cnt_o;

  modport master (
    output id_valid_i, flush_i, rs1_addr_i, rs2_addr_i, rs1_re_i, rs2_re_i,
    output rd_addr_i, rd_we_i, rd_lat_i, rs1_rf_data_i, rs2_rf_data_i, stage_data_i,
    input  id_ready_o, rs1_data_o, rs2_data_o, rs1_fwd_o, rs2_fwd_o, stall_o, stall_cnt_o
  );

  modport slave (
    input  id_valid_i, flush_i, rs1_addr_i, rs2_addr_i, rs1_re_i, rs2_re_i,
    input  rd_addr_i, rd_we_i, rd_lat_i, rs1_rf_data_i, rs2_rf_data_i, stage_data_i,
    output id_ready_o, rs1_data_o, rs2_data_o, rs1_fwd_o, rs2_fwd_o, stall_o, stall_cnt_o
  );
endinterface

// File: rtl/fwd_scoreboard.sv
// Operand forwarding scoreboard: tracks in-flight destinations per pipeline slot,
// selects the youngest producer per source and stalls decode on unready results.
module fwd_scoreboard #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned NREG   = 32,
  parameter int unsigned STAGES = 3
) (
  input  logic           clk,
  input  logic           rst,
  fwd_scoreboard_if.slave bus_io
);
  localparam int unsigned AW = $clog2(NREG);
  localparam int unsigned LW = $clog2(STAGES + 1);
  localparam int          Ns = int'(STAGES);

  logic [STAGES-1:0] valid_q, valid_d;
  logic [AW-1:0]     rd_q  [STAGES];
  logic [AW-1:0]     rd_d  [STAGES];
  logic [LW-1:0]     lat_q [STAGES];
  logic [LW-1:0]     lat_d [STAGES];
  logic [15:0]       cnt_q, cnt_d;

  logic [AW-1:0]     src_addr [2];
  logic              src_re   [2];
  logic [XLEN-1:0]   src_rf   [2];
  logic [XLEN-1:0]   src_data [2];
  logic [STAGES-1:0] src_fwd  [2];
  logic              src_hz   [2];
  logic              stall, accept;
  logic [LW-1:0]     lat_in;

  assign src_addr[0] = bus_io.rs1_addr_i;
  assign src_addr[1] = bus_io.rs2_addr_i;
  assign src_re[0]   = bus_io.rs1_re_i;
  assign src_re[1]   = bus_io.rs2_re_i;
  assign src_rf[0]   = bus_io.rs1_rf_data_i;
  assign src_rf[1]   = bus_io.rs2_rf_data_i;

  // Scan oldest to youngest so the lowest-index match is the one that sticks.
  always_comb begin
    for (int s = 0; s < 2; s++) begin
      src_fwd[s]  = '0;
      src_hz[s]   = 1'b0;
      src_data[s] = src_rf[s];
      if (src_re[s] && (src_addr[s] != '0)) begin
        for (int k = Ns - 1; k >= 0; k--) begin
          if (valid_q[k] && (rd_q[k] == src_addr[s])) begin
            src_fwd[s]    = '0;
            src_fwd[s][k] = 1'b1;
            src_hz[s]     = int'(lat_q[k]) > (k + 1);
            src_data[s]   = bus_io.stage_data_i[k*XLEN +: XLEN];
          end
        end
      end
    end
  end

  assign stall  = bus_io.id_valid_i & (src_hz[0] | src_hz[1]);
  assign accept = bus_io.id_valid_i & ~stall & ~bus_io.flush_i;

  always_comb begin
    lat_in = bus_io.rd_lat_i;
    if (lat_in == '0) begin
      lat_in = LW'(1);
    end else if (int'(lat_in) > Ns) begin
      lat_in = LW'(Ns);
    end
  end

  always_comb begin
    valid_d[0] = accept & bus_io.rd_we_i & (bus_io.rd_addr_i != '0);
    rd_d[0]    = bus_io.rd_addr_i;
    lat_d[0]   = lat_in;
    for (int k = 1; k < Ns; k++) begin
      valid_d[k] = valid_q[k-1];
      rd_d[k]    = rd_q[k-1];
      lat_d[k]   = lat_q[k-1];
    end
    cnt_d = cnt_q;
    if (stall && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  // Payload fields are only meaningful alongside a set valid bit.
  always_ff @(posedge clk) begin
    for (int k = 0; k < Ns; k++) begin
      rd_q[k]  <= rd_d[k];
      lat_q[k] <= lat_d[k];
    end
  end

  assign bus_io.rs1_data_o  = src_data[0];
  assign bus_io.rs2_data_o  = src_data[1];
  assign bus_io.rs1_fwd_o   = src_fwd[0];
  assign bus_io.rs2_fwd_o   = src_fwd[1];
  assign bus_io.stall_o     = stall;
  assign bus_io.id_ready_o  = ~stall;
  assign bus_io.stall_cnt_o = cnt_q;
endmodule

// File: tb/tb_fwd_scoreboard.sv
// Bench for fwd_scoreboard: directed hazard scenarios and random traffic against an
// age-based reference model, plus a deep-pipeline instance for counter saturation.
module tb_fwd_scoreboard;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fwd_scoreboard_if #(.XLEN(32), .NREG(32), .STAGES(3)) sb ();
  fwd_scoreboard_if #(.XLEN(8), .NREG(32), .STAGES(15)) ss ();

  fwd_scoreboard #(.XLEN(32), .NREG(32), .STAGES(3)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (sb)
  );

  fwd_scoreboard #(.XLEN(8), .NREG(32), .STAGES(15)) dut_sat (
    .clk    (clk),
    .rst    (rst),
    .bus_io (ss)
  );

  int checks = 0;
  int failures = 0;
  int cyc_no = 0;

  // Model: each in-flight write remembers how many cycles ago it was issued.
  typedef struct {
    int rd;
    int lat;
    int age;
  } ent_t;
  ent_t q[$];
  int   m_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc_no, obs, exp);
    end
  endtask

  function automatic int clamp_lat(input int l);
    if (l == 0) return 1;
    if (l > 3) return 3;
    return l;
  endfunction

  task automatic lookup(input bit re, input int addr, output logic [2:0] fwd,
                        output logic [31:0] data, output bit hz);
    int best;
    int blat;
    best = 0;
    blat = 0;
    fwd  = 3'b000;
    hz   = 1'b0;
    data = (addr == int'(sb.rs1_addr_i) && re == sb.rs1_re_i) ? sb.rs1_rf_data_i : 32'h0;
    if (re && addr != 0) begin
      foreach (q[i]) begin
        if (q[i].rd == addr && (best == 0 || q[i].age < best)) begin
          best = q[i].age;
          blat = q[i].lat;
        end
      end
    end
    if (best != 0) begin
      fwd  = 3'b001 << (best - 1);
      data = sb.stage_data_i[(best-1)*32 +: 32];
      hz   = blat > best;
    end
  endtask

  task automatic cyc(input bit v, input bit f, input int a1, input bit r1, input int a2,
                     input bit r2, input int rd, input bit we, input int lat, input bit rs);
    logic [2:0]  e_f1, e_f2;
    logic [31:0] e_d1, e_d2;
    bit          hz1, hz2, e_stall, acc;
    sb.id_valid_i    = v;
    sb.flush_i       = f;
    sb.rs1_addr_i    = 5'(a1);
    sb.rs1_re_i      = r1;
    sb.rs2_addr_i    = 5'(a2);
    sb.rs2_re_i      = r2;
    sb.rd_addr_i     = 5'(rd);
    sb.rd_we_i       = we;
    sb.rd_lat_i      = 2'(lat);
    sb.rs1_rf_data_i = $urandom();
    sb.rs2_rf_data_i = $urandom();
    sb.stage_data_i  = {$urandom(), $urandom(), $urandom()};
    rst              = rs;
    #2;
    lookup(r1, a1, e_f1, e_d1, hz1);
    lookup(r2, a2, e_f2, e_d2, hz2);
    if (e_f1 == 3'b000) e_d1 = sb.rs1_rf_data_i;
    if (e_f2 == 3'b000) e_d2 = sb.rs2_rf_data_i;
    e_stall = v && (hz1 || hz2);
    acc     = v && !e_stall && !f;
    chk("stall", 32'(sb.stall_o), 32'(e_stall));
    chk("ready", 32'(sb.id_ready_o), 32'(!e_stall));
    chk("rs1_fwd", 32'(sb.rs1_fwd_o), 32'(e_f1));
    chk("rs2_fwd", 32'(sb.rs2_fwd_o), 32'(e_f2));
    chk("rs1_data", sb.rs1_data_o, e_d1);
    chk("rs2_data", sb.rs2_data_o, e_d2);
    chk("stall_cnt", 32'(sb.stall_cnt_o), 32'(m_cnt));
    @(posedge clk);
    if (rs) begin
      q.delete();
      m_cnt = 0;
    end else begin
      if (e_stall && m_cnt < 65535) m_cnt++;
      foreach (q[i]) q[i].age++;
      while (q.size() > 0 && q[q.size()-1].age > 3) void'(q.pop_back());
      if (acc && we && rd != 0) q.push_front('{rd: rd, lat: clamp_lat(lat), age: 1});
    end
    cyc_no++;
    #1;
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  function automatic int sat_exp(input int c);
    int s;
    s = c - (c + 14) / 15;
    return (s > 65535) ? 65535 : s;
  endfunction

  initial begin
    rst = 1'b1;
    sb.id_valid_i = 0; sb.flush_i = 0; sb.rs1_addr_i = 0; sb.rs2_addr_i = 0;
    sb.rs1_re_i = 0; sb.rs2_re_i = 0; sb.rd_addr_i = 0; sb.rd_we_i = 0; sb.rd_lat_i = 0;
    sb.rs1_rf_data_i = 0; sb.rs2_rf_data_i = 0; sb.stage_data_i = '0;
    ss.id_valid_i = 0; ss.flush_i = 0; ss.rs1_addr_i = 0; ss.rs2_addr_i = 0;
    ss.rs1_re_i = 0; ss.rs2_re_i = 0; ss.rd_addr_i = 0; ss.rd_we_i = 0; ss.rd_lat_i = 0;
    ss.rs1_rf_data_i = 0; ss.rs2_rf_data_i = 0; ss.stage_data_i = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Empty after reset: reads resolve to the register file.
    cyc(1, 0, 3, 1, 4, 1, 0, 0, 1, 0);
    // ALU chain.
    cyc(1, 0, 0, 0, 0, 0, 5, 1, 1, 0);
    cyc(1, 0, 5, 1, 0, 0, 0, 0, 1, 0);
    // Load-use: one stall, then slot 1 forward.
    cyc(1, 0, 0, 0, 0, 0, 6, 1, 2, 0);
    cyc(1, 0, 0, 0, 6, 1, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 6, 1, 0, 0, 1, 0);
    // Youngest producer wins.
    cyc(1, 0, 0, 0, 0, 0, 7, 1, 1, 0);
    cyc(1, 0, 0, 0, 0, 0, 8, 1, 1, 0);
    cyc(1, 0, 0, 0, 0, 0, 7, 1, 1, 0);
    cyc(1, 0, 7, 1, 7, 1, 0, 0, 1, 0);
    // x0 never allocates.
    cyc(1, 0, 0, 0, 0, 0, 0, 1, 3, 0);
    cyc(1, 0, 0, 1, 0, 1, 0, 0, 1, 0);
    // Flush blocks insertion.
    cyc(1, 1, 0, 0, 0, 0, 9, 1, 1, 0);
    cyc(1, 0, 9, 1, 9, 1, 0, 0, 1, 0);
    // Latency 0 clamps to 1: no stall on the next cycle.
    cyc(1, 0, 0, 0, 0, 0, 11, 1, 0, 0);
    cyc(1, 0, 11, 1, 0, 0, 0, 0, 1, 0);
    // Fill three slots, stall, then reset mid-flight.
    cyc(1, 0, 0, 0, 0, 0, 10, 1, 3, 0);
    cyc(1, 0, 0, 0, 0, 0, 12, 1, 3, 0);
    cyc(1, 0, 0, 0, 0, 0, 13, 1, 3, 0);
    cyc(1, 0, 13, 1, 12, 1, 0, 0, 1, 0);
    cyc(1, 0, 13, 1, 10, 1, 14, 1, 1, 1);
    cyc(1, 0, 13, 1, 12, 1, 0, 0, 1, 0);
    idle();

    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 3) != 0), ($urandom_range(0, 9) == 0),
          $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 7),
          $urandom_range(0, 1), $urandom_range(0, 7), ($urandom_range(0, 3) != 0),
          $urandom_range(0, 3), ($urandom_range(0, 99) == 0));
    end

    // Deep-pipeline instance: one accept every 15 cycles, stalls in between.
    ss.id_valid_i = 1; ss.rs1_addr_i = 5'd1; ss.rs1_re_i = 1;
    ss.rd_addr_i = 5'd1; ss.rd_we_i = 1; ss.rd_lat_i = 4'd15;
    #2;
    chk("sat_first_stall", 32'(ss.stall_o), 32'd0);
    chk("sat_cnt_start", 32'(ss.stall_cnt_o), 32'd0);
    for (int c = 1; c <= 70400; c++) begin
      @(posedge clk);
      #1;
      if (c == 1) chk("sat_stall_on", 32'(ss.stall_o), 32'd1);
      if (c == 15 || c == 30000 || c == 70210 || c == 70400)
        chk("sat_cnt", 32'(ss.stall_cnt_o), 32'(sat_exp(c)));
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("sat_cnt_reset", 32'(ss.stall_cnt_o), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
